// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: decode, two-port register file read, load-use bubble.
// Define ID_WB_BYPASS_EN to forward same-cycle write-back into operand and debug reads.
module id_stage_pipe #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [XLEN-1:0] out_data1,
    output logic [XLEN-1:0] out_data2,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);
    localparam int RA = $clog2(NREG);
    localparam logic [6:0] OP_NOP   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // Handshake: a transfer happens on a rising edge where valid && ready; valid never
    // depends on ready, and an offered payload stays stable until it is taken (or flushed).

    logic [XLEN-1:0] rf [NREG];

    logic [6:0] opc;
    logic [4:0] rd, rs1, rs2;
    assign opc = inst[6:0];
    assign rd  = inst[11:7];
    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];

    function automatic logic [XLEN-1:0] read_reg(input logic [4:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        if (a != 5'd0 && 32'(a) < NREG) v = rf[a[RA-1:0]];
`ifdef ID_WB_BYPASS_EN
        if (wb_en && wb_rd != 5'd0 && wb_rd == a) v = wb_data;
`endif
        return v;
    endfunction

    logic [XLEN-1:0] rdata1, rdata2;
    always_comb begin
        rdata1   = read_reg(rs1);
        rdata2   = read_reg(rs2);
        dbg_data = read_reg(dbg_addr);
    end

    // Immediates are assembled as 32 bits and then sign-extended, which also covers XLEN=32 U-type.
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    always_comb begin
        imm32 = 32'd0;
        case (opc)
            OP_NOP, OP_LOAD, OP_JALR: imm32 = {{20{inst[31]}}, inst[31:20]};
            OP_STORE: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OP_BR:    imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm32 = {inst[31:12], 12'd0};
            OP_JAL:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:  imm32 = 32'd0;
        endcase
        imm = XLEN'($signed(imm32));
    end

    logic is_uj, hazard, adv, illegal_in;
    assign is_uj  = (opc == OP_LUI) || (opc == OP_AUIPC) || (opc == OP_JAL);
    assign hazard = out_valid && (out_opcode == OP_LOAD) && (out_rd != 5'd0) &&
                    ((out_rd == rs1) || (!is_uj && out_rd == rs2)) && in_valid;
    assign adv      = out_ready || !out_valid;
    assign in_ready = flush || (adv && !hazard);
    assign illegal_in = (NREG == 16) && (rd[4] || rs1[4] || rs2[4]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wb_en && wb_rd != 5'd0 && 32'(wb_rd) < NREG) begin
            rf[wb_rd[RA-1:0]] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush || (adv && hazard) || (adv && !in_valid)) begin
            // Reset, flush, bubble and idle all leave a NOP in the output register.
            out_valid   <= 1'b0;
            out_opcode  <= OP_NOP;
            out_rd      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_func3   <= '0;
            out_func7   <= '0;
            out_data1   <= '0;
            out_data2   <= '0;
            out_imm     <= '0;
            out_pc      <= '0;
            out_illegal <= 1'b0;
        end else if (adv) begin
            out_valid   <= 1'b1;
            out_opcode  <= opc;
            out_rd      <= rd;
            out_rs1     <= rs1;
            out_rs2     <= rs2;
            out_func3   <= inst[14:12];
            out_func7   <= inst[31:25];
            out_data1   <= rdata1;
            out_data2   <= rdata2;
            out_imm     <= imm;
            out_pc      <= pc;
            out_illegal <= illegal_in;
        end
    end
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a 64-bit/32-register instance plus a 32-bit instance
// sharing the same stimulus (the 32-bit one checks immediate widths).
module tb_id_stage_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] inst = 32'h0000_0013;
    logic [63:0] pc = '0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [63:0] wb_data = '0;
    logic        out_ready = 1'b1;
    logic [4:0]  dbg_addr = '0;

    logic        in_ready, out_valid, out_illegal;
    logic [6:0]  out_opcode, out_func7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_func3;
    logic [63:0] out_data1, out_data2, out_imm, out_pc, dbg_data;

    logic        s_in_ready, s_out_valid, s_out_illegal;
    logic [6:0]  s_out_opcode, s_out_func7;
    logic [4:0]  s_out_rd, s_out_rs1, s_out_rs2;
    logic [2:0]  s_out_func3;
    logic [31:0] s_out_data1, s_out_data2, s_out_imm, s_out_pc, s_dbg_data;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(64), .NREG(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
        .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_func3(out_func3),
        .out_func7(out_func7), .out_data1(out_data1), .out_data2(out_data2),
        .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    id_stage_pipe #(.XLEN(32), .NREG(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .inst(inst),
        .pc(pc[31:0]), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data[31:0]),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_opcode(s_out_opcode),
        .out_rd(s_out_rd), .out_rs1(s_out_rs1), .out_rs2(s_out_rs2), .out_func3(s_out_func3),
        .out_func7(s_out_func7), .out_data1(s_out_data1), .out_data2(s_out_data2),
        .out_imm(s_out_imm), .out_pc(s_out_pc), .out_illegal(s_out_illegal),
        .dbg_addr(dbg_addr), .dbg_data(s_dbg_data)
    );

    // Driver tasks: inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] i, input logic [63:0] p);
        in_valid = 1'b1;
        inst     = i;
        pc       = p;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        inst     = 32'h0000_0013;
        wb_en    = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_valid got %0h exp 0", out_valid);
        end
        tests_run++;
        if (out_opcode !== 7'b0010011) begin
            tests_failed++; $display("FAIL reset_opcode got %0h exp 13", out_opcode);
        end
        tests_run++;
        if (out_imm !== 64'd0 || out_data1 !== 64'd0 || out_pc !== 64'd0 || out_rd !== 5'd0) begin
            tests_failed++; $display("FAIL reset_fields imm %0h d1 %0h pc %0h rd %0h exp 0", out_imm, out_data1, out_pc, out_rd);
        end
        tests_run++;
        if (s_out_valid !== 1'b0 || s_out_opcode !== 7'b0010011) begin
            tests_failed++; $display("FAIL reset_dut32 valid %0h op %0h exp 0/13", s_out_valid, s_out_opcode);
        end
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            tests_run++;
            if (dbg_data !== 64'd0) begin
                tests_failed++; $display("FAIL reset_rf x%0d got %0h exp 0", a, dbg_data);
            end
        end
    endtask

    task automatic test_wb_read();
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'h1234;
        tick();
        wb_en = 1'b0;
        offer(32'hFFF2_8313, 64'h100);
        tick();
        idle();
        tests_run++;
        if (out_valid !== 1'b1 || out_opcode !== 7'b0010011) begin
            tests_failed++; $display("FAIL addi_valid valid %0h op %0h exp 1/13", out_valid, out_opcode);
        end
        tests_run++;
        if (out_data1 !== 64'h1234) begin
            tests_failed++; $display("FAIL addi_data1 got %0h exp 1234", out_data1);
        end
        tests_run++;
        if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            tests_failed++; $display("FAIL addi_imm got %0h exp ffffffffffffffff", out_imm);
        end
        tests_run++;
        if (out_rd !== 5'd6 || out_rs1 !== 5'd5 || out_func3 !== 3'd0 || out_pc !== 64'h100 || out_illegal !== 1'b0) begin
            tests_failed++; $display("FAIL addi_fields rd %0d rs1 %0d f3 %0d pc %0h ill %0h exp 6/5/0/100/0",
                                     out_rd, out_rs1, out_func3, out_pc, out_illegal);
        end
        dbg_addr = 5'd5;
        #1;
        tests_run++;
        if (dbg_data !== 64'h1234) begin
            tests_failed++; $display("FAIL dbg_x5 got %0h exp 1234", dbg_data);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL idle_drain got %0h exp 0", out_valid);
        end
    endtask

    task automatic test_bypass();
        logic [63:0] exp_d1, exp_dbg;
`ifdef ID_WB_BYPASS_EN
        exp_d1 = 64'hAB; exp_dbg = 64'h77;
`else
        exp_d1 = 64'h0; exp_dbg = 64'h0;
`endif
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 64'hAB;
        offer(32'h0003_8433, 64'h200);
        tick();
        idle();
        tests_run++;
        if (out_data1 !== exp_d1 || out_rd !== 5'd8 || out_imm !== 64'd0) begin
            tests_failed++; $display("FAIL bypass_add d1 %0h rd %0d imm %0h exp %0h/8/0", out_data1, out_rd, out_imm, exp_d1);
        end
        dbg_addr = 5'd7;
        #1;
        tests_run++;
        if (dbg_data !== 64'hAB) begin
            tests_failed++; $display("FAIL wb_x7_visible got %0h exp ab", dbg_data);
        end
        wb_en = 1'b1; wb_rd = 5'd9; wb_data = 64'h77; dbg_addr = 5'd9;
        #1;
        tests_run++;
        if (dbg_data !== exp_dbg) begin
            tests_failed++; $display("FAIL dbg_bypass got %0h exp %0h", dbg_data, exp_dbg);
        end
        tick();
        wb_en = 1'b0;
        #1;
        tests_run++;
        if (dbg_data !== 64'h77) begin
            tests_failed++; $display("FAIL dbg_x9_after got %0h exp 77", dbg_data);
        end
    endtask

    task automatic test_load_use();
        // lui whose rs2 field aliases the load rd must not stall.
        offer(32'h0000_B503, 64'h300);
        tick();
        offer(32'h00A0_0637, 64'h304);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL lui_no_stall got %0h exp 1", in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_opcode !== 7'b0110111 || out_imm !== 64'h0000_0000_00A0_0000) begin
            tests_failed++; $display("FAIL lui_issue valid %0h op %0h imm %0h exp 1/37/a00000", out_valid, out_opcode, out_imm);
        end
        offer(32'h0000_B503, 64'h308);
        tick();
        offer(32'h00A5_05B3, 64'h30C);
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL load_use_stall got %0h exp 0", in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_opcode !== 7'b0010011) begin
            tests_failed++; $display("FAIL load_use_bubble valid %0h op %0h exp 0/13", out_valid, out_opcode);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL load_use_release got %0h exp 1", in_ready);
        end
        tick();
        idle();
        tests_run++;
        if (out_valid !== 1'b1 || out_rd !== 5'd11 || out_opcode !== 7'b0110011 || out_pc !== 64'h30C) begin
            tests_failed++; $display("FAIL load_use_issue valid %0h rd %0d op %0h pc %0h exp 1/11/33/30c",
                                     out_valid, out_rd, out_opcode, out_pc);
        end
        tick();
    endtask

    task automatic test_back_pressure_flush();
        offer(32'hFFF2_8313, 64'h400);
        tick();
        out_ready = 1'b0;
        offer(32'h0003_8433, 64'h404);
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++;
            if (in_ready !== 1'b0) begin
                tests_failed++; $display("FAIL hold_in_ready cycle %0d got %0h exp 0", c, in_ready);
            end
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_rd !== 5'd6 || out_pc !== 64'h400 || out_data1 !== 64'h1234) begin
                tests_failed++; $display("FAIL hold_stable cycle %0d valid %0h rd %0d pc %0h d1 %0h exp 1/6/400/1234",
                                         c, out_valid, out_rd, out_pc, out_data1);
            end
        end
        flush = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL flush_in_ready got %0h exp 1", in_ready);
        end
        tick();
        idle();
        tests_run++;
        if (out_valid !== 1'b0 || out_opcode !== 7'b0010011 || out_imm !== 64'd0) begin
            tests_failed++; $display("FAIL flush_clear valid %0h op %0h imm %0h exp 0/13/0", out_valid, out_opcode, out_imm);
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL flush_dropped got %0h exp 0", out_valid);
        end
    endtask

    task automatic test_immediates();
        offer(32'h8000_00B7, 64'h500);
        tick();
        tests_run++;
        if (s_out_imm !== 32'h8000_0000) begin
            tests_failed++; $display("FAIL lui32_imm got %0h exp 80000000", s_out_imm);
        end
        tests_run++;
        if (out_imm !== 64'hFFFF_FFFF_8000_0000) begin
            tests_failed++; $display("FAIL lui64_imm got %0h exp ffffffff80000000", out_imm);
        end
        offer(32'hFFDF_F0EF, 64'h504);
        tick();
        tests_run++;
        if (s_out_imm !== 32'hFFFF_FFFC || s_out_rd !== 5'd1) begin
            tests_failed++; $display("FAIL jal32_imm imm %0h rd %0d exp fffffffc/1", s_out_imm, s_out_rd);
        end
        tests_run++;
        if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            tests_failed++; $display("FAIL jal64_imm got %0h exp fffffffffffffffc", out_imm);
        end
        offer(32'hFE00_0CE3, 64'h508);
        tick();
        tests_run++;
        if (out_imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin
            tests_failed++; $display("FAIL beq_imm got %0h exp fffffffffffffff8", out_imm);
        end
        idle();
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'h55; dbg_addr = 5'd0;
        #1;
        tests_run++;
        if (dbg_data !== 64'd0 || s_dbg_data !== 32'd0) begin
            tests_failed++; $display("FAIL x0_same_cycle got %0h/%0h exp 0", dbg_data, s_dbg_data);
        end
        tick();
        wb_en = 1'b0;
        #1;
        tests_run++;
        if (dbg_data !== 64'd0 || s_dbg_data !== 32'd0) begin
            tests_failed++; $display("FAIL x0_after_write got %0h/%0h exp 0", dbg_data, s_dbg_data);
        end
    endtask

    initial begin
        test_reset();
        test_wb_read();
        test_bypass();
        test_load_use();
        test_back_pressure_flush();
        test_immediates();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
